// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the unified IM/DM memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Top bit of the unified word address selects the region
  localparam logic REGION_IM = 1'b0;
  localparam logic REGION_DM = 1'b1;

  typedef enum logic {
    OWNER_IM = 1'b0,
    OWNER_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter, IM/DM
// The last-grant register moves only when advance is high and a grant is made.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_im,
  input  logic req_dm,
  input  logic advance,
  output logic grant_valid,
  output logic grant_dm
);

  owner_t last_owner;
  owner_t grant_owner;

  always_comb begin
    grant_owner = OWNER_IM;
    if (req_im && req_dm) begin
      grant_owner = (last_owner == OWNER_IM) ? OWNER_DM : OWNER_IM;
    end else if (req_dm) begin
      grant_owner = OWNER_DM;
    end
  end

  assign grant_valid = req_im || req_dm;
  assign grant_dm    = (grant_owner == OWNER_DM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWNER_IM;
    end else if (advance && grant_valid) begin
      last_owner <= grant_owner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - merges fetch and data ports onto one ready-handshake memory
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int IM_AW   = 10,
  parameter int DM_AW   = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [IM_AW-1:0]  im_addr,
  output logic [DW-1:0]     im_rdata,
  output logic              im_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DM_AW-1:0]  dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  input  logic [DW/8-1:0]   dm_be,
  output logic [DW-1:0]     dm_rdata,
  output logic              dm_done,
  output logic              mem_enable,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DM_AW:0]    mem_addr,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic              bus_timeout
);

  // Parameter sanity check: an illegal combination elaborates this empty block
  if (DM_AW < IM_AW || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_out_of_range
  end

  state_t          state;
  owner_t          owner;
  logic            grant_valid;
  logic            grant_dm;
  logic            abort;
  logic            access_end;
  logic [DW-1:0]   rd_val;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_im      (im_req),
    .req_dm      (dm_req),
    .advance     (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_dm    (grant_dm)
  );

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       bus_timeout_q;

  assign wait_cnt_next = wait_cnt + 8'd1;
  // A ready on the same edge as the limit completes normally
  assign abort         = !mem_ready && (wait_cnt_next == TIMEOUT_LIM);
  assign bus_timeout   = bus_timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt      <= 8'd0;
      bus_timeout_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_ACCESS && !mem_ready) begin
      wait_cnt <= wait_cnt_next;
      if (abort) begin
        bus_timeout_q <= 1'b1;
      end
    end
  end
`else
  assign abort       = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  assign access_end = mem_ready || abort;
  assign rd_val     = abort ? {DW{1'b1}} : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWNER_IM;
      im_rdata   <= '0;
      im_done    <= 1'b0;
      dm_rdata   <= '0;
      dm_done    <= 1'b0;
      mem_enable <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_ACCESS;
            owner      <= owner_t'(grant_dm);
            mem_enable <= 1'b1;
            if (grant_dm) begin
              mem_addr  <= {REGION_DM, dm_addr};
              mem_read  <= !dm_we;
              mem_write <= dm_we;
              mem_be    <= dm_be;
              mem_wdata <= dm_wdata;
            end else begin
              mem_addr  <= {REGION_IM, DM_AW'(im_addr)};
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_be    <= '1;
              mem_wdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (access_end) begin
            state      <= ST_DONE;
            mem_enable <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            if (owner == OWNER_DM) begin
              dm_done <= 1'b1;
              if (mem_read) dm_rdata <= rd_val;
            end else begin
              im_done <= 1'b1;
              if (mem_read) im_rdata <= rd_val;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          im_done <= 1'b0;
          dm_done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic        im_done;
  logic        dm_req;
  logic        dm_we;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_enable;
  logic        mem_read;
  logic        mem_write;
  logic [12:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_timeout;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: last winner, per-port read data, sticky timeout
  logic        m_last;
  logic [31:0] m_im_rdata;
  logic [31:0] m_dm_rdata;
  logic        m_to;

  mem_port_arbiter #(
    .IM_AW(10), .DM_AW(12), .DW(32), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_done(im_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {mem_enable, mem_read, mem_write, im_done, dm_done}, 64'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    m_last     = 1'b0;
    m_im_rdata = 32'd0;
    m_dm_rdata = 32'd0;
    m_to       = 1'b0;
    @(negedge clk);
  endtask

  // Called at the negedge of an IDLE cycle with requests already driven;
  // returns at the negedge of the DONE cycle.
  task automatic xact(input int waits, input logic [31:0] rd, output logic owner);
    logic [12:0] ea;
    logic        ewe;
    logic [3:0]  ebe;
    owner  = (im_req && dm_req) ? ~m_last : dm_req;
    m_last = owner;
    ea  = owner ? {1'b1, dm_addr} : {3'b000, im_addr};
    ewe = owner && dm_we;
    ebe = owner ? dm_be : 4'hF;
    step();
    for (int w = 0; w <= waits; w++) begin
      chk("acc_enable", mem_enable, 1);
      chk("acc_addr", mem_addr, ea);
      chk("acc_read", mem_read, !ewe);
      chk("acc_write", mem_write, ewe);
      chk("acc_be", mem_be, ebe);
      if (ewe) chk("acc_wdata", mem_wdata, dm_wdata);
      chk("acc_no_done", {im_done, dm_done}, 0);
      mem_ready = (w == waits);
      mem_rdata = (w == waits) ? rd : $urandom;
      step();
    end
    mem_ready = 1'b0;
    chk("done_im", im_done, !owner);
    chk("done_dm", dm_done, owner);
    chk("done_strobes", {mem_enable, mem_read, mem_write}, 0);
    if (!ewe) begin
      if (owner) m_dm_rdata = rd;
      else       m_im_rdata = rd;
    end
    chk("im_rdata", im_rdata, m_im_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("bus_timeout", bus_timeout, m_to);
  endtask

  initial begin
    logic o;
    int   n;
    im_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
    rst = 1'b0; im_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_im_rdata", im_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_strobes", {mem_enable, mem_read, mem_write, im_done, dm_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_timeout", bus_timeout, 0);
    do_reset();

    // IM fetch, zero wait
    im_addr = 10'h3A; im_req = 1'b1;
    xact(0, 32'hDEADBEEF, o);
    chk("t1_owner", o, 0);
    chk("t1_rdata", im_rdata, 32'hDEADBEEF);
    im_req = 1'b0;
    step();
    check_idle("t1_idle");

    // DM write with two wait states
    dm_addr = 12'h800; dm_be = 4'b0011; dm_we = 1'b1; dm_wdata = $urandom; dm_req = 1'b1;
    xact(2, 32'h12345678, o);
    chk("t2_owner", o, 1);
    chk("t2_dm_rdata_kept", dm_rdata, 0);
    dm_req = 1'b0;
    step();
    check_idle("t2_idle");

    // Contention from reset: DM, IM, DM, IM
    do_reset();
    im_addr = 10'h155; dm_addr = 12'h0F0; dm_we = 1'b0; dm_be = 4'hF;
    im_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xact($urandom_range(0, 3), $urandom, o);
      chk("rr_order", o, (k % 2 == 0));
      if (o) dm_req = 1'b0; else im_req = 1'b0;
      step();
      check_idle("rr_idle");
      im_req = 1'b1; dm_req = 1'b1;
    end
    im_req = 1'b0; dm_req = 1'b0;
    step();

    // Request held through DONE gets exactly one extra access
    im_addr = 10'h2C1; im_req = 1'b1;
    xact(1, $urandom, o);
    step();
    check_idle("hold_idle");
    xact(0, $urandom, o);
    chk("hold_owner", o, 0);
    im_req = 1'b0;
    step();
    check_idle("hold_after1");
    step();
    check_idle("hold_after2");

    // Asynchronous reset in the middle of an access
    dm_we = 1'b0; dm_addr = 12'h7AB; dm_req = 1'b1;
    step();
    chk("arst_in_access", mem_enable, 1);
    rst = 1'b0; dm_req = 1'b0;
    #1;
    chk("arst_strobes", {mem_enable, mem_read, mem_write}, 0);
    @(negedge clk);
    chk("arst_no_done", {im_done, dm_done}, 0);
    @(negedge clk);
    rst = 1'b1;
    m_last = 1'b0; m_im_rdata = 32'd0; m_dm_rdata = 32'd0; m_to = 1'b0;
    @(negedge clk);
    check_idle("arst_idle");
    chk("arst_dm_rdata", dm_rdata, 0);
    im_addr = 10'h011; im_req = 1'b1;
    xact(1, 32'hCAFEF00D, o);
    im_req = 1'b0;
    step();

`ifdef MEM_TIMEOUT_EN
    // Stuck memory on a DM read: aborted after TIMEOUT wait cycles
    dm_we = 1'b0; dm_addr = 12'h321; dm_req = 1'b1;
    step();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!mem_read) break;
      n++;
      step();
    end
    chk("to_cycles", n, 4);
    chk("to_done", dm_done, 1);
    chk("to_rdata", dm_rdata, 32'hFFFFFFFF);
    chk("to_flag", bus_timeout, 1);
    m_dm_rdata = 32'hFFFFFFFF; m_to = 1'b1;
    dm_req = 1'b0;
    step();
    chk("to_sticky", bus_timeout, 1);
`else
    // Long wait never trips a watchdog in the default build
    dm_we = 1'b0; dm_addr = 12'h321; dm_req = 1'b1;
    xact(20, 32'h0BADF00D, o);
    dm_req = 1'b0;
    step();
`endif

    // Random traffic against the model
    for (int r = 0; r < 40; r++) begin
      if (!im_req && $urandom_range(0, 1) == 1) begin
        im_req = 1'b1; im_addr = 10'($urandom);
      end
      if (!dm_req && $urandom_range(0, 1) == 1) begin
        dm_req = 1'b1; dm_addr = 12'($urandom); dm_we = 1'($urandom);
        dm_be = 4'($urandom); dm_wdata = $urandom;
      end
      if (!im_req && !dm_req) begin
        im_req = 1'b1; im_addr = 10'($urandom);
      end
      xact($urandom_range(0, 3), $urandom, o);
      if (o) dm_req = 1'b0; else im_req = 1'b0;
      step();
      check_idle("rand_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
